// File: rtl/inst_fetch_if.sv
// Bundle of the fetch stage's memory, redirect and decode handshakes.
// master: the fetch stage; slave: memory/decode side (or a testbench).
interface inst_fetch_if;
   logic        imem_req_valid;
   logic [31:0] imem_req_addr;
   logic        imem_req_ready;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        dec_ready;
   logic        inst_valid;
   logic [31:0] inst;
   logic [31:0] inst_addr;
   logic        fetch_fault;

   modport master (
      output imem_req_valid, imem_req_addr,
      input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
      input  redirect_valid, redirect_pc, dec_ready,
      output inst_valid, inst, inst_addr, fetch_fault
   );

   modport slave (
      input  imem_req_valid, imem_req_addr,
      output imem_req_ready, imem_rsp_valid, imem_rsp_data,
      output redirect_valid, redirect_pc, dec_ready,
      input  inst_valid, inst, inst_addr, fetch_fault
   );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch stage: holds the PC, issues in-order word fetches with a credit limit,
// buffers responses in a small FIFO and hands them to decode. Redirects flush the FIFO and
// drop every response still in flight.
// Optional feature macro: ALIGN_CHECK_EN (misaligned redirect halts fetch, raises fetch_fault).
module inst_fetch #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int unsigned FIFO_DEPTH = 2
) (
   input  logic         clk,
   input  logic         rst,
   inst_fetch_if.master bus
);
   localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

   typedef enum logic [1:0] {StBoot, StFetch, StHalt} state_e;

   state_e             r_state, w_state_d;
   logic [31:0]        r_pc, w_pc_d;
   logic [31:0]        r_rsp_addr, w_rsp_addr_d;
   logic [CNT_W-1:0]   r_out, w_out_d;
   logic [CNT_W-1:0]   r_drop, w_drop_d;
   logic [CNT_W-1:0]   r_count, w_count_d;
   logic [PTR_W-1:0]   r_wptr, w_wptr_d;
   logic [PTR_W-1:0]   r_rptr, w_rptr_d;
   logic [31:0]        r_fifo_data [FIFO_DEPTH];
   logic [31:0]        r_fifo_addr [FIFO_DEPTH];

   logic               w_req_valid;
   logic               w_acc;
   logic               w_rsp;
   logic               w_push;
   logic               w_pop;
   logic               w_halt_req;
   logic [31:0]        w_target;
   logic [CNT_W:0]     w_credit_used;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      if (p == PTR_W'(FIFO_DEPTH - 1)) return '0;
      return p + PTR_W'(1);
   endfunction

   // Word-aligned redirect target; low bits are never used as an address.
   assign w_target = {bus.redirect_pc[31:2], 2'b00};

`ifdef ALIGN_CHECK_EN
   logic r_fault;
   assign w_halt_req = bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00)
                       && (r_state != StHalt);

   // Sticky fault flag, cleared only by reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_fault <= 1'b0;
      else if (w_halt_req) r_fault <= 1'b1;
   end

   assign bus.fetch_fault = r_fault;
`else
   assign w_halt_req      = 1'b0;
   assign bus.fetch_fault = 1'b0;
`endif

   // Requests outstanding plus entries buffered may never exceed the FIFO size, so every
   // response always has a slot waiting for it.
   assign w_credit_used = {1'b0, r_out} + {1'b0, r_count};
   assign w_req_valid   = (r_state == StFetch) && (w_credit_used < (CNT_W + 1)'(FIFO_DEPTH));
   assign w_acc         = w_req_valid && bus.imem_req_ready;
   assign w_rsp         = bus.imem_rsp_valid;

   assign bus.imem_req_valid = w_req_valid;
   assign bus.imem_req_addr  = r_pc;
   assign bus.inst_valid     = (r_count != '0);
   assign bus.inst           = r_fifo_data[r_rptr];
   assign bus.inst_addr      = r_fifo_addr[r_rptr];

   // FSM next state: boot for one cycle, then fetch; halt only on a misaligned redirect
   always_comb begin
      w_state_d = r_state;
      case (r_state)
         StBoot:  w_state_d = w_halt_req ? StHalt : StFetch;
         StFetch: if (w_halt_req) w_state_d = StHalt;
         StHalt:  w_state_d = StHalt;
         default: w_state_d = StBoot;
      endcase
   end

   // Next-state for PC, credit/drop counters and FIFO pointers
   always_comb begin
      w_out_d      = r_out + CNT_W'(w_acc) - CNT_W'(w_rsp);
      w_drop_d     = r_drop;
      w_pc_d       = r_pc;
      w_rsp_addr_d = r_rsp_addr;
      w_count_d    = r_count;
      w_wptr_d     = r_wptr;
      w_rptr_d     = r_rptr;
      w_push       = 1'b0;
      w_pop        = 1'b0;
      if (bus.redirect_valid) begin
         // Everything still in flight after this cycle belongs to the old stream.
         w_drop_d     = w_out_d;
         w_pc_d       = w_target;
         w_rsp_addr_d = w_target;
         w_count_d    = '0;
         w_wptr_d     = '0;
         w_rptr_d     = '0;
      end else begin
         if (w_rsp && (r_drop != '0)) w_drop_d = r_drop - CNT_W'(1);
         if (w_acc) w_pc_d = r_pc + 32'd4;
         if (r_state == StHalt) begin
            w_count_d = '0;
            w_wptr_d  = '0;
            w_rptr_d  = '0;
         end else begin
            w_push = w_rsp && (r_drop == '0);
            w_pop  = (r_count != '0) && bus.dec_ready;
            if (w_push) begin
               w_wptr_d     = ptr_inc(r_wptr);
               w_rsp_addr_d = r_rsp_addr + 32'd4;
            end
            if (w_pop) w_rptr_d = ptr_inc(r_rptr);
            w_count_d = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
         end
      end
   end

   // State, PC and counter registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= StBoot;
         r_pc       <= RESET_PC;
         r_rsp_addr <= RESET_PC;
         r_out      <= '0;
         r_drop     <= '0;
         r_count    <= '0;
         r_wptr     <= '0;
         r_rptr     <= '0;
      end else begin
         r_state    <= w_state_d;
         r_pc       <= w_pc_d;
         r_rsp_addr <= w_rsp_addr_d;
         r_out      <= w_out_d;
         r_drop     <= w_drop_d;
         r_count    <= w_count_d;
         r_wptr     <= w_wptr_d;
         r_rptr     <= w_rptr_d;
      end
   end

   // FIFO storage: each entry keeps the word and the address it was fetched from
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
            r_fifo_data[i] <= '0;
            r_fifo_addr[i] <= '0;
         end
      end else if (w_push) begin
         r_fifo_data[r_wptr] <= bus.imem_rsp_data;
         r_fifo_addr[r_wptr] <= r_rsp_addr;
      end
   end

   a_no_overflow: assert property (@(posedge clk) disable iff (rst)
      !(w_push && !w_pop && (r_count == CNT_W'(FIFO_DEPTH))));
endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: a queue-based model of fetch stream, in-flight
// requests and the instruction buffer, driven with randomized handshakes and redirects.
module tb_inst_fetch;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam int unsigned DEPTH    = 2;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   inst_fetch_if bus ();

   inst_fetch #(
      .RESET_PC   (RESET_PC),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
      logic [31:0] due;
      logic        stale;
   } mreq_t;

   typedef struct packed {
      logic [31:0] data;
      logic [31:0] addr;
   } ent_t;

   mreq_t       mem_q[$];      // requests accepted by memory, not yet answered
   ent_t        m_fifo[$];     // words decode should see, head first
   logic [31:0] m_pc;
   bit          m_boot, m_halt, m_fault;
   logic [31:0] last_due;
   int          cyc = 0;
   int          n_vec = 0;
   int          n_bad = 0;

   int          p_ready, p_dec, p_redir, lat_min, lat_max;
   bit          allow_misalign;
   int          force_mode = 0;
   logic [31:0] force_pc;
   bit          cap_req_on = 0, cap_inst_on = 0;
   logic [31:0] cap_req[$];
   logic [31:0] cap_inst[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [31:0] q_at(input logic [31:0] q[$], input int i);
      if (i < q.size()) return q[i];
      return 32'hxxxx_xxxx;
   endfunction

   task automatic do_reset();
      rst = 1'b1;
      bus.imem_req_ready = 1'b0;
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = '0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = '0;
      bus.dec_ready      = 1'b0;
      @(negedge clk);
      @(negedge clk);
      cyc += 2;
      chk("rst req_valid", {31'd0, bus.imem_req_valid}, 32'd0);
      chk("rst req_addr", bus.imem_req_addr, RESET_PC);
      chk("rst inst_valid", {31'd0, bus.inst_valid}, 32'd0);
      chk("rst inst", bus.inst, 32'd0);
      chk("rst inst_addr", bus.inst_addr, 32'd0);
      chk("rst fetch_fault", {31'd0, bus.fetch_fault}, 32'd0);
      mem_q.delete();
      m_fifo.delete();
      m_pc     = RESET_PC;
      m_boot   = 1'b1;
      m_halt   = 1'b0;
      m_fault  = 1'b0;
      last_due = cyc;
      rst      = 1'b0;
   endtask

   // One cycle: compare outputs with the model, drive inputs, advance the model.
   task automatic step();
      bit          e_req, rdy, dec, rsp, rv, acc;
      logic [31:0] rpc;
      mreq_t       head, nr;
      int          lat;

      e_req = !m_boot && !m_halt && ((mem_q.size() + m_fifo.size()) < DEPTH);
      chk("req_valid", {31'd0, bus.imem_req_valid}, {31'd0, e_req});
      if (e_req) chk("req_addr", bus.imem_req_addr, m_pc);
      chk("inst_valid", {31'd0, bus.inst_valid}, {31'd0, m_fifo.size() != 0});
      if (m_fifo.size() != 0) begin
         chk("inst", bus.inst, m_fifo[0].data);
         chk("inst_addr", bus.inst_addr, m_fifo[0].addr);
      end
      chk("fetch_fault", {31'd0, bus.fetch_fault}, {31'd0, m_fault});

      rdy = ($urandom_range(99) < p_ready);
      dec = ($urandom_range(99) < p_dec);
      rsp = (mem_q.size() != 0) && (mem_q[0].due <= cyc);
      rv  = !m_boot && ($urandom_range(999) < p_redir);
      rpc = ($urandom_range(7) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'h0000_0FFC);
      if (allow_misalign && $urandom_range(3) == 0) rpc[1:0] = 2'($urandom_range(1, 3));
      if (!m_boot && ((force_mode == 1 && mem_q.size() == DEPTH) ||
                      (force_mode == 2 && rsp && e_req && rdy) || force_mode == 3)) begin
         rv  = 1'b1;
         rpc = force_pc;
         force_mode = 0;
         cap_inst.delete();
         cap_inst_on = 1'b1;
      end else begin
         if (cap_inst_on && bus.inst_valid && dec && !rv) cap_inst.push_back(bus.inst_addr);
      end
      if (cap_req_on && bus.imem_req_valid && rdy) cap_req.push_back(bus.imem_req_addr);

      bus.imem_req_ready = rdy;
      bus.imem_rsp_valid = rsp;
      bus.imem_rsp_data  = rsp ? mem_q[0].data : $urandom;
      bus.redirect_valid = rv;
      bus.redirect_pc    = rv ? rpc : $urandom;
      bus.dec_ready      = dec;

      acc = e_req && rdy;
      head = '0;
      if (rsp) head = mem_q.pop_front();
      lat = $urandom_range(lat_max, lat_min);
      nr.addr  = m_pc;
      nr.data  = $urandom;
      nr.due   = ((cyc + lat) > last_due) ? (cyc + lat) : (last_due + 1);
      nr.stale = 1'b0;
      if (m_boot) begin
         m_boot = 1'b0;
      end else if (rv && !m_halt) begin
         m_fifo.delete();
         foreach (mem_q[i]) mem_q[i].stale = 1'b1;
         if (acc) begin
            nr.stale = 1'b1;
            mem_q.push_back(nr);
            last_due = nr.due;
         end
         m_pc = {rpc[31:2], 2'b00};
`ifdef ALIGN_CHECK_EN
         if (rpc[1:0] != 2'b00) begin
            m_halt  = 1'b1;
            m_fault = 1'b1;
         end
`endif
      end else begin
         if (m_fifo.size() != 0 && dec) void'(m_fifo.pop_front());
         if (rsp && !head.stale) m_fifo.push_back({head.data, head.addr});
         if (acc) begin
            mem_q.push_back(nr);
            last_due = nr.due;
            m_pc     = m_pc + 32'd4;
         end
      end
      if (m_halt) m_fifo.delete();

      @(negedge clk);
      cyc++;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      allow_misalign = 1'b0;
      do_reset();

      // Streaming with an always-ready, single-cycle memory
      p_ready = 100; p_dec = 100; p_redir = 0; lat_min = 1; lat_max = 1;
      cap_req_on = 1'b1; cap_inst_on = 1'b1;
      run(12);
      cap_req_on = 1'b0; cap_inst_on = 1'b0;
      chk("p1 req0", q_at(cap_req, 0), 32'h0);
      chk("p1 req1", q_at(cap_req, 1), 32'h4);
      chk("p1 req2", q_at(cap_req, 2), 32'h8);
      chk("p1 inst0", q_at(cap_inst, 0), 32'h0);
      chk("p1 inst1", q_at(cap_inst, 1), 32'h4);
      chk("p1 inst2", q_at(cap_inst, 2), 32'h8);

      // Decode stalled: buffer fills, requests stop
      p_dec = 0;
      run(5);
      chk("p2 stall req_valid", {31'd0, bus.imem_req_valid}, 32'd0);
      chk("p2 stall inst_valid", {31'd0, bus.inst_valid}, 32'd1);
      p_dec = 100;
      run(6);

      // Redirect with two requests in flight
      lat_min = 3; lat_max = 3;
      force_mode = 1; force_pc = 32'h0000_0100;
      run(20);
      chk("p3 inst0", q_at(cap_inst, 0), 32'h100);
      chk("p3 inst1", q_at(cap_inst, 1), 32'h104);
      cap_inst_on = 1'b0;

      // Redirect coinciding with a response and a request accept
      lat_min = 1; lat_max = 1;
      force_mode = 2; force_pc = 32'h0000_0200;
      run(20);
      chk("p4 inst0", q_at(cap_inst, 0), 32'h200);
      chk("p4 inst1", q_at(cap_inst, 1), 32'h204);
      cap_inst_on = 1'b0;
      force_mode = 0;

      // Memory not ready: address must hold
      p_ready = 0;
      run(3);
      p_ready = 100;
      run(4);

      // Randomized traffic
      p_ready = 70; p_dec = 70; p_redir = 40; lat_min = 1; lat_max = 4;
      run(1500);

      // Mid-run reset, then more random traffic
      do_reset();
`ifndef ALIGN_CHECK_EN
      allow_misalign = 1'b1;
`endif
      run(1500);
      allow_misalign = 1'b0;

      // Misaligned redirect target
      p_redir = 0; p_ready = 100; p_dec = 100;
      run(8);
      force_mode = 3; force_pc = 32'h0000_0102;
      run(12);
`ifdef ALIGN_CHECK_EN
      chk("p6 fetch_fault", {31'd0, bus.fetch_fault}, 32'd1);
      chk("p6 req_valid", {31'd0, bus.imem_req_valid}, 32'd0);
      chk("p6 inst_valid", {31'd0, bus.inst_valid}, 32'd0);
`else
      chk("p6 inst0", q_at(cap_inst, 0), 32'h100);
      chk("p6 fetch_fault", {31'd0, bus.fetch_fault}, 32'd0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
